// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the level sequencer game controller.
//   state_t        : top-level game state encoding
//   PW_TABLE       : per-level password, stored 32 bits wide and resized to
//                    PW_WIDTH by the consumer (zero-extended or truncated)
//   TIME_TABLE     : per-level countdown start value, tens digit only (BCD)
//   pw_entry/time_entry : indexed lookups into the two tables
// Optional feature macro used by the design files: RETRY_EN
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_FAIL = 3'd4
    } state_t;

    localparam int PW_TABLE_WIDTH = 32;
    localparam int MAX_LEVELS     = 8;

    localparam logic [PW_TABLE_WIDTH-1:0] PW_TABLE [0:MAX_LEVELS-1] = '{
        32'h0000_0333,
        32'h0000_02CD,
        32'h0000_0394,
        32'h0000_01A5,
        32'h0000_00F0,
        32'h0000_02B7,
        32'h0000_03C9,
        32'h0000_0156
    };

    localparam logic [3:0] TIME_TABLE [0:MAX_LEVELS-1] = '{
        4'd9, 4'd6, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3
    };

    function automatic logic [PW_TABLE_WIDTH-1:0] pw_entry(input logic [2:0] idx);
        return PW_TABLE[idx];
    endfunction

    function automatic logic [3:0] time_entry(input logic [2:0] idx);
        return TIME_TABLE[idx];
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
// Two-digit BCD down-counter used as the per-level timer.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (clears to 00)
//   load        : load load_tens into the tens digit and 0 into the ones digit
//   load_tens   : tens digit to load
//   dec         : decrement by one second (ignored while already at 00)
//   tens, ones  : registered BCD digits
//   is_zero     : digits currently read 00
// load has priority over dec.
// -----------------------------------------------------------------------------
module bcd_countdown (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       is_zero
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    assign is_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign tens    = tens_q;
    assign ones    = ones_q;

    // Borrow from the tens digit when the ones digit wraps 0 -> 9; saturate at 00.
    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            tens_d = load_tens;
            ones_d = 4'd0;
        end else if (dec && !is_zero) begin
            if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
            end else begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
// Game controller stepping a player through NUM_LEVELS levels, each with its
// own password and countdown. Losing (fail input or timer at 00) ends the game,
// winning the last level ends it with win_state.
// Parameters:
//   NUM_LEVELS (1..8), PW_WIDTH, LIVES (0..7, meaningful only with RETRY_EN)
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   success, fail, tick : level solved / external failure / 1 Hz strobe
//   time_tens/time_ones : BCD countdown
//   current_level       : 1..NUM_LEVELS, 0 while idle
//   update              : one-cycle pulse when password and timer are loaded
//   new_password        : password of the current level, held between updates
//   fail_state/win_state: terminal flags, held until reset
//   lives_left          : remaining retries
// Optional feature: define RETRY_EN to let a failure consume a life and replay
// the current level instead of ending the game.
// -----------------------------------------------------------------------------
module level_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int PW_WIDTH   = 10,
    parameter int LIVES      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                success,
    input  logic                fail,
    input  logic                tick,
    output logic [3:0]          time_tens,
    output logic [3:0]          time_ones,
    output logic [3:0]          current_level,
    output logic                update,
    output logic [PW_WIDTH-1:0] new_password,
    output logic                fail_state,
    output logic                win_state,
    output logic [2:0]          lives_left
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_LEVELS - 1);

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          level_q, level_d;
    logic                update_q, update_d;
    logic [PW_WIDTH-1:0] pw_q, pw_d;
    logic                fail_q, fail_d;
    logic                win_q, win_d;

    logic                load_req;
    logic [2:0]          load_idx;
    logic                timer_load;
    logic [3:0]          timer_load_tens;
    logic                timer_dec;
    logic                timer_zero;

`ifdef RETRY_EN
    logic [2:0]          lives_q, lives_d;
`endif

    bcd_countdown u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_tens (timer_load_tens),
        .dec       (timer_dec),
        .tens      (time_tens),
        .ones      (time_ones),
        .is_zero   (timer_zero)
    );

    // Next-state logic. Any path into LOAD goes through load_req so that the
    // password, level number, timer reload and update pulse always move together.
    // Ticks only reach the timer when PLAY is not being left this cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        level_d   = level_q;
        update_d  = 1'b0;
        pw_d      = pw_q;
        fail_d    = fail_q;
        win_d     = win_q;
        load_req  = 1'b0;
        load_idx  = idx_q;
        timer_dec = 1'b0;
`ifdef RETRY_EN
        lives_d   = lives_q;
`endif

        case (state_q)
            ST_IDLE: begin
                load_req = 1'b1;
                load_idx = 3'd0;
            end
            ST_LOAD: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (fail || timer_zero) begin
`ifdef RETRY_EN
                    if (lives_q != 3'd0) begin
                        lives_d  = lives_q - 3'd1;
                        load_req = 1'b1;
                        load_idx = idx_q;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end
`else
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
`endif
                end else if (success) begin
                    if (idx_q < LAST_IDX) begin
                        load_req = 1'b1;
                        load_idx = idx_q + 3'd1;
                    end else begin
                        state_d = ST_WIN;
                        win_d   = 1'b1;
                    end
                end else begin
                    timer_dec = tick;
                end
            end
            ST_WIN, ST_FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_req) begin
            state_d  = ST_LOAD;
            idx_d    = load_idx;
            level_d  = {1'b0, load_idx} + 4'd1;
            update_d = 1'b1;
            pw_d     = PW_WIDTH'(pw_entry(load_idx));
        end

        timer_load      = load_req;
        timer_load_tens = time_entry(load_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            level_q  <= 4'd0;
            update_q <= 1'b0;
            pw_q     <= '0;
            fail_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            level_q  <= level_d;
            update_q <= update_d;
            pw_q     <= pw_d;
            fail_q   <= fail_d;
            win_q    <= win_d;
        end
    end

`ifdef RETRY_EN
    // Lives are refilled only by reset; a retry consumes one.
    always_ff @(posedge clk) begin
        if (reset) begin
            lives_q <= 3'(LIVES);
        end else begin
            lives_q <= lives_d;
        end
    end

    assign lives_left = lives_q;
`else
    // No retries in this build: the counter reads 0 whatever LIVES is set to.
    assign lives_left = 3'(LIVES) & 3'd0;
`endif

    assign current_level = level_q;
    assign update        = update_q;
    assign new_password  = pw_q;
    assign fail_state    = fail_q;
    assign win_state     = win_q;

endmodule

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
// Directed game scenarios followed by random play, every cycle compared with a
// behavioural game model that tracks the remaining time as plain seconds.
// Works in both builds (RETRY_EN defined or not).
// -----------------------------------------------------------------------------
module tb_level_sequencer;

    localparam int NUM_LEVELS = 3;
    localparam int PW_WIDTH   = 10;
    localparam int LIVES      = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                success = 1'b0;
    logic                fail = 1'b0;
    logic                tick = 1'b0;
    logic [3:0]          time_tens;
    logic [3:0]          time_ones;
    logic [3:0]          current_level;
    logic                update;
    logic [PW_WIDTH-1:0] new_password;
    logic                fail_state;
    logic                win_state;
    logic [2:0]          lives_left;

    int n_asserts  = 0;
    int n_failures = 0;

    level_sequencer #(
        .NUM_LEVELS (NUM_LEVELS),
        .PW_WIDTH   (PW_WIDTH),
        .LIVES      (LIVES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .success       (success),
        .fail          (fail),
        .tick          (tick),
        .time_tens     (time_tens),
        .time_ones     (time_ones),
        .current_level (current_level),
        .update        (update),
        .new_password  (new_password),
        .fail_state    (fail_state),
        .win_state     (win_state),
        .lives_left    (lives_left)
    );

    always #5 clk = ~clk;

    // Reference game description: passwords and starting seconds per level.
    int exp_pw   [0:2] = '{'h333, 'h2CD, 'h394};
    int exp_secs [0:2] = '{90, 60, 30};

`ifdef RETRY_EN
    localparam int START_LIVES = LIVES;
`else
    localparam int START_LIVES = 0;
`endif

    // Model phases: waiting to start, showing a fresh level, playing, over.
    localparam int PH_IDLE = 0;
    localparam int PH_SHOW = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_WON  = 3;
    localparam int PH_LOST = 4;

    int m_phase  = PH_IDLE;
    int m_level  = 0;
    int m_secs   = 0;
    int m_lives  = START_LIVES;
    int m_pw     = 0;
    int m_update = 0;
    int m_win    = 0;
    int m_lost   = 0;

    function automatic void start_level(input int lvl);
        m_phase  = PH_SHOW;
        m_level  = lvl;
        m_secs   = exp_secs[lvl-1];
        m_pw     = exp_pw[lvl-1];
        m_update = 1;
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit f, input bit t);
        if (r) begin
            m_phase = PH_IDLE; m_level = 0; m_secs = 0; m_pw = 0;
            m_update = 0; m_win = 0; m_lost = 0; m_lives = START_LIVES;
            return;
        end
        m_update = 0;
        case (m_phase)
            PH_IDLE: start_level(1);
            PH_SHOW: m_phase = PH_PLAY;
            PH_PLAY: begin
                if (f || m_secs == 0) begin
                    if (m_lives > 0) begin
                        m_lives = m_lives - 1;
                        start_level(m_level);
                    end else begin
                        m_phase = PH_LOST;
                        m_lost  = 1;
                    end
                end else if (s) begin
                    if (m_level < NUM_LEVELS) start_level(m_level + 1);
                    else begin
                        m_phase = PH_WON;
                        m_win   = 1;
                    end
                end else if (t) begin
                    m_secs = m_secs - 1;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string ctx);
        checkOne({ctx, ".time_tens"},  32'(time_tens),     32'(m_secs / 10));
        checkOne({ctx, ".time_ones"},  32'(time_ones),     32'(m_secs % 10));
        checkOne({ctx, ".level"},      32'(current_level), 32'(m_level));
        checkOne({ctx, ".update"},     32'(update),        32'(m_update));
        checkOne({ctx, ".password"},   32'(new_password),  32'(m_pw));
        checkOne({ctx, ".fail_state"}, 32'(fail_state),    32'(m_lost));
        checkOne({ctx, ".win_state"},  32'(win_state),     32'(m_win));
        checkOne({ctx, ".lives_left"}, 32'(lives_left),    32'(m_lives));
    endtask

    // One clock cycle: drive inputs mid-cycle, advance the model at the edge,
    // compare shortly after the edge.
    task automatic applyStimulus(input string ctx, input bit r, input bit s, input bit f, input bit t);
        @(negedge clk);
        reset = r; success = s; fail = f; tick = t;
        @(posedge clk);
        model_step(r, s, f, t);
        #1;
        checkOutput(ctx);
    endtask

    initial begin
        $display("[TB] start");

        // Reset, then the first level loads on the second cycle.
        applyStimulus("reset", 1, 0, 0, 0);
        checkOne("reset.update", 32'(update), 32'd0);
        checkOne("reset.level", 32'(current_level), 32'd0);
        applyStimulus("load1", 0, 0, 0, 0);
        checkOne("load1.update", 32'(update), 32'd1);
        checkOne("load1.pw", 32'(new_password), 32'h333);
        checkOne("load1.time", 32'({time_tens, time_ones}), 32'h90);

        // Let the level-1 clock run out.
        applyStimulus("play1", 0, 0, 0, 0);
        for (int i = 0; i < 90; i++) applyStimulus("count", 0, 0, 0, 1);
        checkOne("timeout.time", 32'({time_tens, time_ones}), 32'h00);
        applyStimulus("timeout", 0, 0, 0, 1);
`ifndef RETRY_EN
        checkOne("timeout.fail_state", 32'(fail_state), 32'd1);
`endif
        for (int i = 0; i < 3; i++) applyStimulus("hold_lost", 0, i[0], 1, 1);

        // Win through all three levels.
        applyStimulus("reset2", 1, 0, 0, 0);
        applyStimulus("load1b", 0, 0, 0, 0);
        applyStimulus("play1b", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("tick1b", 0, 0, 0, 1);
        applyStimulus("succ1", 0, 1, 0, 1);
        checkOne("succ1.pw", 32'(new_password), 32'h2CD);
        checkOne("succ1.time", 32'({time_tens, time_ones}), 32'h60);
        applyStimulus("play2", 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) applyStimulus("tick2", 0, 0, 0, 1);
        applyStimulus("succ2", 0, 1, 0, 0);
        checkOne("succ2.pw", 32'(new_password), 32'h394);
        checkOne("succ2.time", 32'({time_tens, time_ones}), 32'h30);
        applyStimulus("play3", 0, 0, 0, 0);
        applyStimulus("succ3", 0, 1, 0, 1);
        checkOne("succ3.win", 32'(win_state), 32'd1);
        checkOne("succ3.update", 32'(update), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus("hold_win", 0, 1, i[0], 1);

        // Success and fail together.
        applyStimulus("reset3", 1, 0, 0, 0);
        applyStimulus("load1c", 0, 0, 0, 0);
        applyStimulus("play1c", 0, 0, 0, 0);
        applyStimulus("both", 0, 1, 1, 0);
`ifndef RETRY_EN
        checkOne("both.fail_state", 32'(fail_state), 32'd1);
        checkOne("both.update", 32'(update), 32'd0);
`endif
        applyStimulus("after_both", 0, 0, 0, 0);

        // Repeated failures at level 2 (retries only with RETRY_EN).
        applyStimulus("reset4", 1, 0, 0, 0);
        applyStimulus("load1d", 0, 0, 0, 0);
        applyStimulus("play1d", 0, 0, 0, 0);
        applyStimulus("succ1d", 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("play2d", 0, 0, 0, 1);
            applyStimulus("fail2d", 0, 0, 1, 1);
        end
        applyStimulus("after_fails", 0, 0, 0, 0);

        // Reset during the level-3 load cycle, then restart.
        applyStimulus("reset5", 1, 0, 0, 0);
        applyStimulus("load1e", 0, 0, 0, 0);
        applyStimulus("play1e", 0, 0, 0, 0);
        applyStimulus("succ1e", 0, 1, 0, 0);
        applyStimulus("play2e", 0, 0, 0, 0);
        applyStimulus("succ2e", 0, 1, 0, 0);
        applyStimulus("load_rst", 1, 1, 1, 1);
        checkOne("load_rst.level", 32'(current_level), 32'd0);
        checkOne("load_rst.time", 32'({time_tens, time_ones}), 32'h00);
        applyStimulus("restart", 0, 0, 0, 0);
        checkOne("restart.level", 32'(current_level), 32'd1);

        // Random play.
        for (int i = 0; i < 600; i++) begin
            applyStimulus("random",
                          ($urandom_range(0, 79) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule
